cuckoo_hash_table: RTL
======================

# cuckoo_hash_table

Parametrised N-way cuckoo hash table with multi-hop eviction, a one-entry overflow stash and a full valid/ready handshake on both request and response sides. Each table uses its own H3 hash configured by a single packed Q-matrix parameter. The block accepts one operation at a time: read, insert/update, delete or no-op. It sits between a request-issuing client and downstream response logic, which may stall the block through `ready_i`.

## Interface
- KEY_WIDTH, 8: key bits.
- DATA_WIDTH, 32: payload bits.
- NUM_TABLES, 2: number of hash tables; must be ≥2.
- ADDR_WIDTH, 2: index bits per table, giving 2^ADDR_WIDTH slots per table.
- MAX_KICKS, 4: eviction limit; must be ≥1.
- Q_MATRIX, 32'h0090_0009: H3 rows, width NUM_TABLES*KEY_WIDTH*ADDR_WIDTH.
  - The ADDR_WIDTH-bit row for table t, key bit k starts at bit (t*KEY_WIDTH+k)*ADDR_WIDTH.
  - hash_t(key) = XOR of the rows for table t whose key bit is 1.
  - The default gives table0 = key[1:0] and table1 = key[3:2].
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i && ready_o.
- op_i  in  2  operation: 00 NOP, 01 READ, 10 WRITE, 11 DELETE.
- key_i  in  KEY_WIDTH  request key.
- data_i  in  DATA_WIDTH  write payload.
- valid_o  out  1  response valid.
- ready_i  in  1  response consumed when valid_o && ready_i.
- read_data_o  out  DATA_WIDTH  payload on a READ hit; 0 otherwise.
- status_o  out  3  0 OK, 1 NOT_FOUND, 2 FULL, 3 UPDATED, 4 STASHED.
- kick_count_o  out  clog2(MAX_KICKS+1)  evictions performed by the current or last WRITE.
- occupancy_o  out  clog2(NUM_TABLES*2^ADDR_WIDTH+2)  valid entries, including the stash.

## Operation
- Storage:
  - Each table slot holds {key, data} plus a valid flag.
  - Slot RAMs have synchronous read and are not reset.
  - Valid flags, the stash (key, data, valid) and occupancy are reset.
- FSM states: IDLE, LOOKUP, COMPARE, KICK_RD, KICK_CMP, RESP.
- IDLE: ready_o=1. On handshake, capture op/key/data, clear kick count, go to LOOKUP.
- LOOKUP: present hash_t(key) to every table. Go to COMPARE.
- COMPARE: hit = valid && stored key == key, checked in table order 0..N-1, then the stash. A key lives in at most one location.
  - NOP: status OK.
  - READ: on hit, read_data_o = stored data, status OK; on miss, NOT_FOUND.
  - DELETE: on hit, clear the valid flag, occupancy−1, status OK; on miss, NOT_FOUND.
  - WRITE hit: overwrite data in place, status UPDATED. Stash state is irrelevant.
  - WRITE miss, some slot free: write to the lowest-index free table, occupancy+1, status OK.
  - WRITE miss, no slot free, stash full: status FULL, no state change.
  - WRITE miss, no slot free, stash empty:
    - Write the new element into table 0 and take its old element as in-hand.
    - Set count=1 and next table=1, then go to KICK_RD.
- KICK_RD: read table t at hash_t(in-hand key).
- KICK_CMP:
  - Slot free: write in-hand, occupancy+1, status OK.
  - Else if count==MAX_KICKS: move in-hand to the stash, occupancy+1, status STASHED.
  - Else: swap in-hand with the slot, count+1, t=(t+1) mod N, go back to KICK_RD.
- RESP:
  - valid_o=1 and outputs are held stable until ready_i.
  - On handshake, go to IDLE. valid_o and ready_o are never both high.
- No element is ever lost. The FULL decision is made before any table is modified.

## Timing
- Reset values:
  - ready_o=0 in the reset cycle and 1 in the first cycle after reset.
  - valid_o=0, read_data_o=0, status_o=0, kick_count_o=0, occupancy_o=0.
  - All valid flags and the stash are cleared. The FSM goes to IDLE.
- Reset in any state aborts the pending operation; no response is produced.
- Latency, counted from the accept edge:
  - Non-kicking operations: valid_o rises 3 cycles later.
  - Each KICK_RD/KICK_CMP pair adds 2 cycles.
  - Worst case is 3+2*MAX_KICKS.
- valid_i is ignored while ready_o=0.
- Table writes and flag updates take effect at the clock edge leaving COMPARE or KICK_CMP. They are visible to the next accepted operation.

## Test plan
- Reset, then READ key 0x05 -> NOT_FOUND, read_data_o=0, valid_o exactly 3 cycles after accept.
- WRITE 0x00/0xA, WRITE 0x10/0xB -> both OK, T0[0]=0x00, T1[0]=0x10, occupancy 2. Then READ 0x10 -> OK, 0xB. Then WRITE 0x10/0xC -> UPDATED; READ 0x10 -> 0xC.
- After the previous test, WRITE 0x20:
  - Response: STASHED, kick_count_o=4, valid_o 11 cycles after accept.
  - Final state: T0[0]=0x10, T1[0]=0x20, stash=0x00, occupancy 3.
  - Follow-up reads of 0x00, 0x10 and 0x20 all hit.
- Then WRITE 0x30 -> FULL, with contents and occupancy unchanged. Then DELETE 0x00 (stashed) -> OK, occupancy 2. Then WRITE 0x30 -> STASHED.
- Hold ready_i=0 for 5 cycles during RESP -> valid_o and all outputs stay stable, ready_o=0, and a concurrent valid_i is not accepted.
- Assert reset during KICK_RD of a WRITE -> no response, occupancy 0, and all reads return NOT_FOUND.

Source files
------------

// File: rtl/cuckoo_hash_table.sv
// cuckoo_hash_table: N-way cuckoo hash table with H3 hashing per table, bounded
// multi-hop eviction, a one-entry overflow stash and valid/ready handshakes on
// both the request and response sides. One operation is in flight at a time.
module cuckoo_hash_table #(
    parameter int KEY_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TABLES = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int MAX_KICKS  = 4,
    parameter logic [NUM_TABLES*KEY_WIDTH*ADDR_WIDTH-1:0] Q_MATRIX = 32'h0090_0009,
    localparam int KICK_W = $clog2(MAX_KICKS + 1),
    localparam int OCC_W  = $clog2(NUM_TABLES * (2 ** ADDR_WIDTH) + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [1:0]            op_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic [2:0]            status_o,
    output logic [KICK_W-1:0]     kick_count_o,
    output logic [OCC_W-1:0]      occupancy_o
);

    localparam int SLOTS = 2 ** ADDR_WIDTH;
    localparam int TBL_W = $clog2(NUM_TABLES);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_COMPARE, S_KICK_RD, S_KICK_CMP, S_RESP} state_e;
    typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_DELETE} op_e;
    typedef enum logic [2:0] {ST_OK, ST_NOT_FOUND, ST_FULL, ST_UPDATED, ST_STASHED} status_e;

    // H3 hash: XOR of the Q-matrix rows of table t selected by the set key bits.
    function automatic logic [ADDR_WIDTH-1:0] hash_f(input logic [KEY_WIDTH-1:0] key, input int t);
        logic [ADDR_WIDTH-1:0] h;
        h = '0;
        for (int k = 0; k < KEY_WIDTH; k++)
            if (key[k]) h ^= Q_MATRIX[(t*KEY_WIDTH+k)*ADDR_WIDTH +: ADDR_WIDTH];
        return h;
    endfunction

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d, in_key_q, in_key_d, stash_key_q, stash_key_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, in_data_q, in_data_d, stash_data_q, stash_data_d;
    logic                  stash_valid_q, stash_valid_d;
    logic [TBL_W-1:0]      tbl_q, tbl_d;
    logic [KICK_W-1:0]     kick_q, kick_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    status_e               status_q, status_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [KEY_WIDTH-1:0]  tbl_key_q  [NUM_TABLES][SLOTS];
    logic [DATA_WIDTH-1:0] tbl_data_q [NUM_TABLES][SLOTS];
    logic [SLOTS-1:0]      tbl_valid_q [NUM_TABLES];
    logic [KEY_WIDTH-1:0]  rd_key_q  [NUM_TABLES];
    logic [DATA_WIDTH-1:0] rd_data_q [NUM_TABLES];
    logic [ADDR_WIDTH-1:0] rd_idx_q  [NUM_TABLES];
    logic [ADDR_WIDTH-1:0] rd_addr   [NUM_TABLES];

    logic                  rd_en, wr_en, flag_en, flag_val;
    logic [TBL_W-1:0]      wr_tbl;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [KEY_WIDTH-1:0]  wr_key, lookup_key;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_TABLES-1:0] slot_valid;
    logic                  tbl_hit, tbl_free, stash_hit;
    logic [TBL_W-1:0]      hit_tbl, free_tbl;

    assign ready_o      = (state_q == S_IDLE) && !reset;
    assign valid_o      = (state_q == S_RESP);
    assign read_data_o  = rdata_q;
    assign status_o     = status_q;
    assign kick_count_o = kick_q;
    assign occupancy_o  = occ_q;

    // Control and stash registers, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_NOP;
            key_q         <= '0;
            data_q        <= '0;
            in_key_q      <= '0;
            in_data_q     <= '0;
            stash_key_q   <= '0;
            stash_data_q  <= '0;
            stash_valid_q <= 1'b0;
            tbl_q         <= '0;
            kick_q        <= '0;
            occ_q         <= '0;
            status_q      <= ST_OK;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            key_q         <= key_d;
            data_q        <= data_d;
            in_key_q      <= in_key_d;
            in_data_q     <= in_data_d;
            stash_key_q   <= stash_key_d;
            stash_data_q  <= stash_data_d;
            stash_valid_q <= stash_valid_d;
            tbl_q         <= tbl_d;
            kick_q        <= kick_d;
            occ_q         <= occ_d;
            status_q      <= status_d;
            rdata_q       <= rdata_d;
        end
    end

    // Slot payload storage plus a registered read of the addressed slot in every table.
    // NOTE: payload RAMs have no reset; the valid flags alone decide whether a slot holds an entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_key_q[wr_tbl][wr_idx]  <= wr_key;
            tbl_data_q[wr_tbl][wr_idx] <= wr_data;
        end
        if (rd_en) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                rd_key_q[t]  <= tbl_key_q[t][rd_addr[t]];
                rd_data_q[t] <= tbl_data_q[t][rd_addr[t]];
                rd_idx_q[t]  <= rd_addr[t];
            end
        end
    end

    // Per-slot valid flags, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TABLES; t++) tbl_valid_q[t] <= '0;
        end else if (flag_en) begin
            tbl_valid_q[wr_tbl][wr_idx] <= flag_val;
        end
    end

    // Hash addresses and hit/free detection; the descending loop leaves the lowest table winning.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        lookup_key = (state_q == S_KICK_RD) ? in_key_q : key_q;
        rd_addr    = '{default: '0};
        slot_valid = '0;
        tbl_hit    = 1'b0;
        hit_tbl    = '0;
        tbl_free   = 1'b0;
        free_tbl   = '0;
        for (int t = NUM_TABLES - 1; t >= 0; t--) begin
            rd_addr[t]    = hash_f(lookup_key, t);
            slot_valid[t] = tbl_valid_q[t][rd_idx_q[t]];
            if (slot_valid[t] && rd_key_q[t] == key_q) begin
                tbl_hit = 1'b1;
                hit_tbl = TBL_W'(t);
            end
            if (!slot_valid[t]) begin
                tbl_free = 1'b1;
                free_tbl = TBL_W'(t);
            end
        end
        stash_hit = stash_valid_q && (stash_key_q == key_q);
    end

    // Next-state, table write port and response decisions.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        key_d         = key_q;
        data_d        = data_q;
        in_key_d      = in_key_q;
        in_data_d     = in_data_q;
        stash_key_d   = stash_key_q;
        stash_data_d  = stash_data_q;
        stash_valid_d = stash_valid_q;
        tbl_d         = tbl_q;
        kick_d        = kick_q;
        occ_d         = occ_q;
        status_d      = status_q;
        rdata_d       = rdata_q;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        flag_en       = 1'b0;
        flag_val      = 1'b0;
        wr_tbl        = '0;
        wr_idx        = '0;
        wr_key        = key_q;
        wr_data       = data_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_o) begin
                    op_d    = op_e'(op_i);
                    key_d   = key_i;
                    data_d  = data_i;
                    kick_d  = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                rd_en   = 1'b1;
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                rdata_d  = '0;
                status_d = ST_OK;
                state_d  = S_RESP;
                case (op_q)
                    OP_READ: begin
                        if (tbl_hit)        rdata_d  = rd_data_q[hit_tbl];
                        else if (stash_hit) rdata_d  = stash_data_q;
                        else                status_d = ST_NOT_FOUND;
                    end
                    OP_DELETE: begin
                        if (tbl_hit) begin
                            flag_en = 1'b1;
                            wr_tbl  = hit_tbl;
                            wr_idx  = rd_idx_q[hit_tbl];
                            occ_d   = occ_q - OCC_W'(1);
                        end else if (stash_hit) begin
                            stash_valid_d = 1'b0;
                            occ_d         = occ_q - OCC_W'(1);
                        end else begin
                            status_d = ST_NOT_FOUND;
                        end
                    end
                    OP_WRITE: begin
                        if (tbl_hit) begin
                            wr_en    = 1'b1;
                            wr_tbl   = hit_tbl;
                            wr_idx   = rd_idx_q[hit_tbl];
                            status_d = ST_UPDATED;
                        end else if (stash_hit) begin
                            stash_data_d = data_q;
                            status_d     = ST_UPDATED;
                        end else if (tbl_free) begin
                            wr_en    = 1'b1;
                            flag_en  = 1'b1;
                            flag_val = 1'b1;
                            wr_tbl   = free_tbl;
                            wr_idx   = rd_idx_q[free_tbl];
                            occ_d    = occ_q + OCC_W'(1);
                        end else if (stash_valid_q) begin
                            // Nowhere for a displaced element to land: refuse before touching tables.
                            status_d = ST_FULL;
                        end else begin
                            wr_en     = 1'b1;
                            wr_idx    = rd_idx_q[0];
                            in_key_d  = rd_key_q[0];
                            in_data_d = rd_data_q[0];
                            kick_d    = KICK_W'(1);
                            tbl_d     = TBL_W'(1);
                            state_d   = S_KICK_RD;
                        end
                    end
                    default: ;
                endcase
            end
            S_KICK_RD: begin
                rd_en   = 1'b1;
                state_d = S_KICK_CMP;
            end
            S_KICK_CMP: begin
                wr_tbl  = tbl_q;
                wr_idx  = rd_idx_q[tbl_q];
                wr_key  = in_key_q;
                wr_data = in_data_q;
                if (!slot_valid[tbl_q]) begin
                    wr_en    = 1'b1;
                    flag_en  = 1'b1;
                    flag_val = 1'b1;
                    occ_d    = occ_q + OCC_W'(1);
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (kick_q == KICK_W'(MAX_KICKS)) begin
                    stash_key_d   = in_key_q;
                    stash_data_d  = in_data_q;
                    stash_valid_d = 1'b1;
                    occ_d         = occ_q + OCC_W'(1);
                    status_d      = ST_STASHED;
                    state_d       = S_RESP;
                end else begin
                    wr_en     = 1'b1;
                    in_key_d  = rd_key_q[tbl_q];
                    in_data_d = rd_data_q[tbl_q];
                    kick_d    = kick_q + KICK_W'(1);
                    tbl_d     = (tbl_q == TBL_W'(NUM_TABLES - 1)) ? '0 : tbl_q + TBL_W'(1);
                    state_d   = S_KICK_RD;
                end
            end
            S_RESP: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
